// File: rtl/alu_issue_stage.sv
// Decode/operand-fetch stage ahead of the ALU: decodes op, reads A/B from a small regfile, counts issues.
// Latency: 1 cycle from accept to out_valid; full throughput of one op per cycle.
// Backpressure: in_ready = !out_valid || out_ready; operands hold while out_valid && !out_ready.
// Optional build macro ALU_ISSUE_WB_BYPASS_EN: same-cycle write-back is forwarded into captured operands.
module alu_issue_stage #(
    parameter int NREGS = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       alu_a,
    output logic [4:0]       alu_b,
    output logic [15:0]      alu_imm,
    output logic [4:0]       alu_shift,
    output logic [5:0]       alu_ctrl,
    input  logic             wb_en,
    input  logic [2:0]       wb_addr,
    input  logic [5:0]       wb_data,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    logic [4:0]       regs_q [NREGS];
    logic [4:0]       regs_d [NREGS];
    logic [4:0]       rf_src [NREGS];

    logic             out_valid_q, out_valid_d;
    logic [4:0]       alu_a_q, alu_a_d;
    logic [4:0]       alu_b_q, alu_b_d;
    logic [15:0]      alu_imm_q, alu_imm_d;
    logic [4:0]       alu_shift_q, alu_shift_d;
    logic [5:0]       alu_ctrl_q, alu_ctrl_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;

    logic [5:0]       op;
    logic [2:0]       rs, rt;
    logic             legal, use_rt;
    logic [15:0]      dec_imm;
    logic [4:0]       dec_shift;
    logic [4:0]       rd_a, rd_b;
    logic             accept, issue;

    // Bits that carry no information for this stage.
    logic             unused_bits;
    assign unused_bits = ^{wb_data[5], in_instr[19:16]};

    assign op       = in_instr[31:26];
    assign rs       = in_instr[25:23];
    assign rt       = in_instr[22:20];
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && legal;

    // Register file next state: r0 is hardwired, out-of-range addresses never match.
    always_comb begin
        regs_d    = regs_q;
        regs_d[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (wb_en && wb_addr == 3'(i)) regs_d[i] = wb_data[4:0];
        end
    end

    // Operand source: post-write values when forwarding is built in, else pre-edge contents.
    always_comb begin
`ifdef ALU_ISSUE_WB_BYPASS_EN
        rf_src = regs_d;
`else
        rf_src = regs_q;
`endif
    end

    // Register reads; r0 and indices beyond NREGS read as zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (rs == 3'(i)) rd_a = rf_src[i];
            if (rt == 3'(i)) rd_b = rf_src[i];
        end
    end

    // Opcode decode into operand selection.
    always_comb begin
        legal     = 1'b0;
        use_rt    = 1'b1;
        dec_imm   = '0;
        dec_shift = '0;
        case (op)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4: legal = 1'b1;
            6'd5, 6'd6: begin
                legal     = 1'b1;
                dec_shift = in_instr[4:0];
            end
            6'd10, 6'd11: begin
                legal   = 1'b1;
                use_rt  = 1'b0;
                dec_imm = in_instr[15:0];
            end
            default: legal = 1'b0;
        endcase
    end

    // Output register and counter next state; illegal ops are consumed but never issued.
    always_comb begin
        out_valid_d  = out_valid_q && !out_ready;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_imm_d    = alu_imm_q;
        alu_shift_d  = alu_shift_q;
        alu_ctrl_d   = alu_ctrl_q;
        illegal_d    = accept && !legal;
        issued_cnt_d = issued_cnt_q + CNT_W'(issue);
        if (accept) out_valid_d = legal;
        if (issue) begin
            alu_a_d     = rd_a;
            alu_b_d     = use_rt ? rd_b : 5'd0;
            alu_imm_d   = dec_imm;
            alu_shift_d = dec_shift;
            alu_ctrl_d  = op;
        end
    end

    // State registers; reset discards any in-flight operands immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            out_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_imm_q    <= '0;
            alu_shift_q  <= '0;
            alu_ctrl_q   <= '0;
            illegal_q    <= 1'b0;
            issued_cnt_q <= '0;
        end else begin
            regs_q       <= regs_d;
            out_valid_q  <= out_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_imm_q    <= alu_imm_d;
            alu_shift_q  <= alu_shift_d;
            alu_ctrl_q   <= alu_ctrl_d;
            illegal_q    <= illegal_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_imm    = alu_imm_q;
    assign alu_shift  = alu_shift_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign illegal    = illegal_q;
    assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: vector table plus hand-written stall/bypass/wrap/reset sequences.
// Counter built 4 bits wide so the wrap case is reachable in a few cycles.
// Expectations follow ALU_ISSUE_WB_BYPASS_EN when it is defined for the build.
module tb_alu_issue_stage;

    localparam int NREGS = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      in_instr;
    logic [4:0]       alu_a, alu_b, alu_shift;
    logic [15:0]      alu_imm;
    logic [5:0]       alu_ctrl;
    logic             wb_en, illegal;
    logic [2:0]       wb_addr;
    logic [5:0]       wb_data;
    logic [CNT_W-1:0] issued_cnt;

    alu_issue_stage #(.NREGS(NREGS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_shift(alu_shift), .alu_ctrl(alu_ctrl),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [2:0]  rs, rt;
        logic [15:0] imm;
        logic [4:0]  a, b, sh;
        logic [15:0] eimm;
        logic        ill;
    } vec_t;

    vec_t             vt [9];
    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [4:0]       exp_byp;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rs,
                                       input logic [2:0] rt, input logic [15:0] imm);
        return {op, rs, rt, 4'b0000, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [2:0] addr, input logic [5:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        step();
        wb_en   = 1'b0;
    endtask

    initial begin
        //        op     rs    rt    imm       a      b      sh    eimm      ill
        vt[0] = '{6'h00, 3'd1, 3'd2, 16'h0000, 5'd5,  5'd3,  5'd0, 16'h0000, 1'b0};
        vt[1] = '{6'h0A, 3'd1, 3'd0, 16'h00FF, 5'd5,  5'd0,  5'd0, 16'h00FF, 1'b0};
        vt[2] = '{6'h05, 3'd2, 3'd4, 16'h0003, 5'd3,  5'd17, 5'd3, 16'h0000, 1'b0};
        vt[3] = '{6'h06, 3'd7, 3'd1, 16'hFFE4, 5'd31, 5'd5,  5'd4, 16'h0000, 1'b0};
        vt[4] = '{6'h0B, 3'd4, 3'd7, 16'h1234, 5'd17, 5'd0,  5'd0, 16'h1234, 1'b0};
        vt[5] = '{6'h3F, 3'd1, 3'd2, 16'h0000, 5'd0,  5'd0,  5'd0, 16'h0000, 1'b1};
        vt[6] = '{6'h03, 3'd0, 3'd7, 16'h0055, 5'd0,  5'd31, 5'd0, 16'h0000, 1'b0};
        vt[7] = '{6'h07, 3'd2, 3'd2, 16'h0000, 5'd0,  5'd0,  5'd0, 16'h0000, 1'b1};
        vt[8] = '{6'h04, 3'd2, 3'd2, 16'h0000, 5'd3,  5'd3,  5'd0, 16'h0000, 1'b0};

`ifdef ALU_ISSUE_WB_BYPASS_EN
        exp_byp = 5'h07;
`else
        exp_byp = 5'h00;
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_cnt", 32'(issued_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        step();
        rst_n = 1'b1;
        step();

        wb_write(3'd1, 6'h05);
        wb_write(3'd2, 6'h03);
        wb_write(3'd4, 6'h31);   // stores 5'h11
        wb_write(3'd7, 6'h3F);   // stores 5'h1F

        for (int i = 0; i < 9; i++) begin
            in_instr  = mk(vt[i].op, vt[i].rs, vt[i].rt, vt[i].imm);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            if (!vt[i].ill) exp_cnt++;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(!vt[i].ill));
            chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vt[i].ill));
            chk($sformatf("v%0d_cnt", i), 32'(issued_cnt), 32'(exp_cnt));
            if (!vt[i].ill) begin
                chk($sformatf("v%0d_a", i), 32'(alu_a), 32'(vt[i].a));
                chk($sformatf("v%0d_b", i), 32'(alu_b), 32'(vt[i].b));
                chk($sformatf("v%0d_imm", i), 32'(alu_imm), 32'(vt[i].eimm));
                chk($sformatf("v%0d_shift", i), 32'(alu_shift), 32'(vt[i].sh));
                chk($sformatf("v%0d_ctrl", i), 32'(alu_ctrl), 32'(vt[i].op));
            end
            step();
            chk($sformatf("v%0d_illegal_drop", i), 32'(illegal), 0);
            chk($sformatf("v%0d_drain", i), 32'(out_valid), 0);
        end

        // Stall: first op held, second waits three cycles, then both move once each.
        in_instr = mk(6'h00, 3'd1, 3'd2, 16'h0); in_valid = 1'b1; out_ready = 1'b0;
        step();
        exp_cnt++;
        in_instr = mk(6'h01, 3'd4, 3'd7, 16'h0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 0);
            chk($sformatf("stall%0d_a", c), 32'(alu_a), 5);
            chk($sformatf("stall%0d_b", c), 32'(alu_b), 3);
            chk($sformatf("stall%0d_cnt", c), 32'(issued_cnt), 32'(exp_cnt));
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        exp_cnt++;
        chk("stall_next_valid", 32'(out_valid), 1);
        chk("stall_next_a", 32'(alu_a), 17);
        chk("stall_next_b", 32'(alu_b), 31);
        chk("stall_next_ctrl", 32'(alu_ctrl), 1);
        chk("stall_next_cnt", 32'(issued_cnt), 32'(exp_cnt));
        step();
        chk("stall_drain", 32'(out_valid), 0);
        chk("stall_no_dup_cnt", 32'(issued_cnt), 32'(exp_cnt));

        // Same-cycle write-back to R3 and read of R3.
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 6'h27;
        in_instr = mk(6'h00, 3'd3, 3'd0, 16'h0); in_valid = 1'b1;
        step();
        wb_en = 1'b0;
        exp_cnt++;
        chk("byp_a", 32'(alu_a), 32'(exp_byp));
        step();
        exp_cnt++;
        chk("byp_after_a", 32'(alu_a), 7);
        // Write to r0 alongside a read of r0, then read r0 again.
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 6'h1F;
        in_instr = mk(6'h00, 3'd0, 3'd0, 16'h0);
        step();
        wb_en = 1'b0;
        exp_cnt++;
        chk("r0_same_cycle", 32'(alu_a), 0);
        step();
        exp_cnt++;
        chk("r0_after_write", 32'(alu_a), 0);
        chk("r0_cnt", 32'(issued_cnt), 32'(exp_cnt));

        // Back-to-back issues until the counter is all-ones, then one more wraps it.
        in_instr = mk(6'h00, 3'd1, 3'd2, 16'h0);
        for (int k = 0; k < 16; k++) begin
            if (exp_cnt == '1) break;
            step();
            exp_cnt++;
        end
        chk("cnt_all_ones", 32'(issued_cnt), 32'(exp_cnt));
        step();
        exp_cnt++;
        chk("cnt_wrap", 32'(issued_cnt), 0);
        chk("cnt_wrap_model", 32'(exp_cnt), 32'(issued_cnt));
        chk("wrap_valid", 32'(out_valid), 1);

        // Reset while operands are held.
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        chk("held_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_alu_a", 32'(alu_a), 0);
        chk("midrst_cnt", 32'(issued_cnt), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
